uart_rx_frame: RTL and testbench

UART receiver, the stage directly downstream of the UART transmitter. It consumes the serial TX_OUT stream and recovers P_DATA.
- Runs on an oversampling clock (PRESCALE clocks per bit).
- Frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Raises a one-cycle DATA_VALID strobe per good frame; flags parity and stop errors.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 55 +++++
 rtl/uart_rx_frame.sv | 128 ++++++++++++
 tb/tb_uart_rx_frame.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, legal oversampling ratios
// and the parity-type encoding also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_t;

  localparam int CNT_W       = 6;
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything other than 16 or 32 falls back to 8x oversampling.
  function automatic logic [CNT_W-1:0] decode_prescale(input logic [31:0] p);
    if (p == 32'(PRESCALE_16)) return CNT_W'(PRESCALE_16);
    if (p == 32'(PRESCALE_32)) return CNT_W'(PRESCALE_32);
    return CNT_W'(PRESCALE_8);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge/bit counters and a 3-sample
// majority vote taken around the middle of each bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             data_phase,
  input  logic [CNT_W-1:0] prescale,
  input  logic             rx,
  output logic             sample_done,
  output logic             bit_end,
  output logic             bit_value,
  output logic [BIT_W-1:0] bit_cnt
);

  logic [CNT_W-1:0] edge_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [2:0]       samples_reg;
  logic [CNT_W-1:0] half;

  assign half        = prescale >> 1;
  assign bit_end     = active && (edge_cnt_reg == prescale - CNT_W'(1));
  assign sample_done = active && (edge_cnt_reg == half + CNT_W'(2));
  assign bit_value   = (samples_reg[0] & samples_reg[1]) |
                       (samples_reg[0] & samples_reg[2]) |
                       (samples_reg[1] & samples_reg[2]);
  assign bit_cnt     = bit_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else begin
      edge_cnt_reg <= bit_end ? '0 : edge_cnt_reg + CNT_W'(1);
      if (bit_end && data_phase)
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
    end
  end

  // Taps land on edge_cnt = half-1, half, half+1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    always_ff @(posedge clk) begin
      if (rst)
        samples_reg[gi] <= 1'b0;
      else if (active && (edge_cnt_reg == half + CNT_W'(gi) - CNT_W'(1)))
        samples_reg[gi] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start/data/parity/stop framing, parity and stop checking,
// and one-cycle result strobes issued before the stop bit has ended.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  rx_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      prescale_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_fail_reg;
  logic [DATA_WIDTH-1:0] p_data_reg;
  logic                  data_valid_reg;
  logic                  par_err_reg;
  logic                  stp_err_reg;

  logic             active;
  logic             data_phase;
  logic             sample_done;
  logic             bit_end;
  logic             bit_value;
  logic [BIT_W-1:0] bit_cnt;
  logic             start_seen;
  logic             stop_check;
  logic             stp_fail;

  assign active     = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                      (state_reg == ST_PARITY) || (state_reg == ST_STOP);
  assign data_phase = (state_reg == ST_DATA);
  assign start_seen = (state_reg == ST_IDLE) && !RX_IN;
  assign stop_check = (state_reg == ST_STOP) && sample_done;
  assign stp_fail   = !bit_value;

  uart_rx_sampler #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIT_W     (BIT_W)
  ) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .active     (active),
    .data_phase (data_phase),
    .prescale   (prescale_reg),
    .rx         (RX_IN),
    .sample_done(sample_done),
    .bit_end    (bit_end),
    .bit_value  (bit_value),
    .bit_cnt    (bit_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!RX_IN) state_next = ST_START;
      ST_START: begin
        if (sample_done && bit_value) state_next = ST_IDLE;
        else if (bit_end)             state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == BIT_W'(DATA_WIDTH - 1)))
          state_next = par_en_reg ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      // Leave mid stop bit so a start edge right at its end is not missed.
      ST_STOP:   if (sample_done) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_reg   <= CNT_W'(PRESCALE_8);
      par_en_reg     <= 1'b0;
      par_typ_reg    <= PAR_EVEN;
      shift_reg      <= '0;
      par_fail_reg   <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      if (start_seen) begin
        prescale_reg <= decode_prescale(32'(PRESCALE));
        par_en_reg   <= PAR_EN;
        par_typ_reg  <= PAR_TYP;
        par_fail_reg <= 1'b0;
      end
      if (data_phase && sample_done)
        shift_reg <= {bit_value, shift_reg[DATA_WIDTH-1:1]};
      if ((state_reg == ST_PARITY) && sample_done)
        par_fail_reg <= bit_value != ((^shift_reg) ^ par_typ_reg);
      // Strobes are registered on entry to DONE and last exactly that cycle.
      data_valid_reg <= stop_check && !par_fail_reg && !stp_fail;
      par_err_reg    <= stop_check && par_fail_reg;
      stp_err_reg    <= stop_check && stp_fail;
      if (stop_check && !par_fail_reg && !stp_fail)
        p_data_reg <= shift_reg;
    end
  end

  assign P_DATA     = p_data_reg;
  assign DATA_VALID = data_valid_reg;
  assign PAR_ERR    = par_err_reg;
  assign STP_ERR    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of single frames plus hand-written
// sequences for start glitches, back-to-back frames and mid-frame reset.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en  = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int strobe_cyc = -1;
  logic dv_prev = 1'b0;

  uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx),
    .PRESCALE  (prescale),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else
      $display("ok   %s = %0d", name, act);
  endtask

  // Strobe monitor, sampled mid-cycle; cyc is the index of the edge just passed.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      strobe_cyc = cyc;
      check("dv_single_cycle", int'(dv_prev), 0);
    end
    if (par_err) begin pe_cnt++; strobe_cyc = cyc; end
    if (stp_err) begin se_cnt++; strobe_cyc = cyc; end
    dv_prev = data_valid;
  end

  // Caller is #1 after an edge; frame cycle c is sampled at edge t0+c.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pbit, input logic stop, input int glitch_c,
                            input int abort_c, output int t0);
    logic bits [11];
    int n;
    n = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = pbit;
    bits[n-1] = stop;
    t0 = cyc + 1;
    for (int c = 0; c < n * p; c++) begin
      if (abort_c >= 0 && c == abort_c + 1) begin
        check("abort_p_data_cleared", int'(p_data), 0);
        check("abort_no_strobe", int'({data_valid, par_err, stp_err}), 0);
        rst = 1'b0;
      end
      if (abort_c >= 0 && c == abort_c) rst = 1'b1;
      if (abort_c >= 0 && c >= abort_c) rx = 1'b1;
      else rx = bits[c / p] ^ (c == glitch_c);
      @(posedge clk); #1;
    end
    rx = 1'b1;
  endtask

  task automatic clear_counts();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; strobe_cyc = -1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         pin;
    int         p;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stop;
    int         glitch;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs [8];
  int t0;
  int n_bits;

  initial begin
    vecs[0] = '{8'hA5,  8,  8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h65, 16, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1, 0, 0, 8'h65};
    vecs[2] = '{8'h0F, 32, 32, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1, 0, 0, 8'h0F};
    vecs[3] = '{8'h65, 16, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 1, 0, 8'h0F};
    vecs[4] = '{8'h3C,  8,  8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 0, 1, 8'h0F};
    vecs[5] = '{8'hC3, 12,  8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1, 0, 0, 8'hC3};
    vecs[6] = '{8'h00,  8,  8, 1'b0, 1'b0, 1'b0, 1'b1, 37, 1, 0, 0, 8'h00};
    vecs[7] = '{8'h01,  8,  8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0, 1, 1, 8'h00};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_p_data", int'(p_data), 0);
    check("reset_data_valid", int'(data_valid), 0);
    check("reset_par_err", int'(par_err), 0);
    check("reset_stp_err", int'(stp_err), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      prescale = 6'(vecs[i].pin);
      par_en   = vecs[i].pe;
      par_typ  = vecs[i].pt;
      clear_counts();
      send_frame(vecs[i].data, vecs[i].p, vecs[i].pe, vecs[i].pbit, vecs[i].stop,
                 vecs[i].glitch, -1, t0);
      repeat (4) @(posedge clk);
      #1;
      $display("vec %0d: data=%02h P=%0d dv=%0d pe=%0d se=%0d p_data=%02h",
               i, vecs[i].data, vecs[i].pin, dv_cnt, pe_cnt, se_cnt, p_data);
      check($sformatf("vec%0d_dv", i), dv_cnt, vecs[i].exp_dv);
      check($sformatf("vec%0d_par_err", i), pe_cnt, vecs[i].exp_pe);
      check($sformatf("vec%0d_stp_err", i), se_cnt, vecs[i].exp_se);
      check($sformatf("vec%0d_p_data", i), int'(p_data), int'(vecs[i].exp_pdata));
      n_bits = vecs[i].pe ? 11 : 10;
      check($sformatf("vec%0d_strobe_cycle", i), strobe_cyc - t0,
            (n_bits - 1) * vecs[i].p + vecs[i].p / 2 + 3);
    end

    // False start: line low for 2 cycles only.
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    clear_counts();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("false_start_strobes", dv_cnt + pe_cnt + se_cnt, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    $display("after false start: dv=%0d p_data=%02h", dv_cnt, p_data);
    check("after_false_start_dv", dv_cnt, 1);
    check("after_false_start_p_data", int'(p_data), 8'h81);

    // Back-to-back: second start edge lands right at the first stop bit end.
    clear_counts();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    $display("back-to-back: dv=%0d p_data=%02h", dv_cnt, p_data);
    check("b2b_dv_count", dv_cnt, 2);
    check("b2b_err_count", pe_cnt + se_cnt, 0);
    check("b2b_p_data", int'(p_data), 8'h34);

    // Reset in the middle of the second of two frames.
    clear_counts();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, -1, 40, t0);
    repeat (10) @(posedge clk);
    #1;
    $display("mid-frame reset: dv=%0d p_data=%02h", dv_cnt, p_data);
    check("reset_abort_dv_count", dv_cnt, 1);
    check("reset_abort_err_count", pe_cnt + se_cnt, 0);
    check("reset_abort_p_data", int'(p_data), 0);
    clear_counts();
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    repeat (4) @(posedge clk);
    #1;
    $display("after reset: dv=%0d p_data=%02h", dv_cnt, p_data);
    check("after_reset_dv", dv_cnt, 1);
    check("after_reset_p_data", int'(p_data), 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
